// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key search controller.
package rc4_pkg;

  localparam int KEY_W_DEF   = 24;
  localparam int MSG_LEN_DEF = 32;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_RUN,
    ST_KSA_RUN,
    ST_PRGA_RUN,
    ST_CHECK,
    ST_NEXT_KEY,
    ST_DONE
  } state_e;

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/rc4_text_checker.sv
// Counts decrypted bytes of one run and flags any byte that
// is not a lowercase letter or space.
module rc4_text_checker
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wren,
  input  logic [7:0] data,
  output logic       bad,
  output logic [5:0] count
);

  logic [5:0] count_q, count_d;
  logic       bad_q, bad_d;

  always_comb begin
    count_d = count_q;
    bad_d   = bad_q;
    if (clear) begin
      count_d = '0;
      bad_d   = 1'b0;
    end else if (wren) begin
      count_d = count_q + 6'd1;
      if (!is_text(data)) bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bad_q   <= bad_d;
    end
  end

  assign bad   = bad_q;
  assign count = count_q;

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Sequences init/ksa/prga for each candidate key, owns the
// S-RAM port and judges each key from the decrypted text.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                   KEY_WIDTH = KEY_W_DEF,
  parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   MSG_LEN   = MSG_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 finish,
  output logic                 found,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 init_start,
  output logic                 ksa_start,
  output logic                 prga_start,
  input  logic                 init_finish,
  input  logic                 ksa_finish,
  input  logic                 prga_finish,
  input  logic [7:0]           init_address_s,
  input  logic [7:0]           ksa_address_s,
  input  logic [7:0]           prga_address_s,
  input  logic [7:0]           init_data_s,
  input  logic [7:0]           ksa_data_s,
  input  logic [7:0]           prga_data_s,
  input  logic                 init_wren_s,
  input  logic                 ksa_wren_s,
  input  logic                 prga_wren_s,
  output logic [7:0]           address_s,
  output logic [7:0]           data_s,
  output logic                 wren_s,
  input  logic                 prga_wren_d,
  input  logic [7:0]           prga_data_d
);

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 found_q, found_d;
  logic                 entry_q, entry_d;

  logic       chk_clear;
  logic       chk_wren;
  logic       chk_bad;
  logic [5:0] chk_count;
  logic       run_bad;

  // Count and bad flag restart on the KSA->PRGA transition.
  assign chk_clear = (state_q == ST_KSA_RUN) && ksa_finish;
  assign chk_wren  = (state_q == ST_PRGA_RUN) && prga_wren_d;
  assign run_bad   = chk_bad || (int'(chk_count) != MSG_LEN);

  rc4_text_checker u_checker (
    .clk   (clk),
    .reset (reset),
    .clear (chk_clear),
    .wren  (chk_wren),
    .data  (prga_data_d),
    .bad   (chk_bad),
    .count (chk_count)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    found_d = found_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT_RUN;
          key_d   = KEY_START;
          found_d = 1'b0;
        end
      end
      ST_INIT_RUN: if (init_finish) state_d = ST_KSA_RUN;
      ST_KSA_RUN:  if (ksa_finish)  state_d = ST_PRGA_RUN;
      ST_PRGA_RUN: if (prga_finish) state_d = ST_CHECK;
      ST_CHECK: begin
        if (!run_bad) begin
          state_d = ST_DONE;
          found_d = 1'b1;
        end else if (key_q == KEY_MAX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_NEXT_KEY;
        end
      end
      ST_NEXT_KEY: begin
        key_d   = key_q + KEY_WIDTH'(1);
        state_d = ST_INIT_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // entry_q marks the first cycle spent in a newly entered state.
  assign entry_d = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= KEY_START;
      found_q <= 1'b0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      found_q <= found_d;
      entry_q <= entry_d;
    end
  end

  assign init_start = (state_q == ST_INIT_RUN) && entry_q;
  assign ksa_start  = (state_q == ST_KSA_RUN)  && entry_q;
  assign prga_start = (state_q == ST_PRGA_RUN) && entry_q;
  assign finish     = (state_q == ST_DONE);
  assign found      = found_q;
  assign key        = key_q;

  always_comb begin
    address_s = '0;
    data_s    = '0;
    wren_s    = 1'b0;
    unique case (state_q)
      ST_INIT_RUN: begin
        address_s = init_address_s;
        data_s    = init_data_s;
        wren_s    = init_wren_s;
      end
      ST_KSA_RUN: begin
        address_s = ksa_address_s;
        data_s    = ksa_data_s;
        wren_s    = ksa_wren_s;
      end
      ST_PRGA_RUN: begin
        address_s = prga_address_s;
        data_s    = prga_data_s;
        wren_s    = prga_wren_s;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Scoreboard bench for rc4_key_search_ctrl with behavioural
// phase models and a text-rule reference model.
module tb_rc4_key_search_ctrl;

  localparam int KW   = 24;
  localparam logic [KW-1:0] KS = 24'd0;
  localparam logic [KW-1:0] KM = 24'd3;
  localparam int NRUN = 4;
  localparam int ML   = 32;

  logic clk = 0, reset = 1, start = 0;
  logic finish, found;
  logic [KW-1:0] key;
  logic init_start, ksa_start, prga_start;
  logic init_finish = 0, ksa_finish = 0, prga_finish = 0;
  logic [7:0] init_address_s = 0, ksa_address_s = 0, prga_address_s = 0;
  logic [7:0] init_data_s = 0, ksa_data_s = 0, prga_data_s = 0;
  logic init_wren_s = 0, ksa_wren_s = 0, prga_wren_s = 0;
  logic [7:0] address_s, data_s;
  logic wren_s;
  logic prga_wren_d = 0;
  logic [7:0] prga_data_d = 0;

  rc4_key_search_ctrl #(
    .KEY_WIDTH(KW), .KEY_START(KS), .KEY_MAX(KM), .MSG_LEN(ML)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .found(found), .key(key),
    .init_start(init_start), .ksa_start(ksa_start),
    .prga_start(prga_start),
    .init_finish(init_finish), .ksa_finish(ksa_finish),
    .prga_finish(prga_finish),
    .init_address_s(init_address_s), .ksa_address_s(ksa_address_s),
    .prga_address_s(prga_address_s),
    .init_data_s(init_data_s), .ksa_data_s(ksa_data_s),
    .prga_data_s(prga_data_s),
    .init_wren_s(init_wren_s), .ksa_wren_s(ksa_wren_s),
    .prga_wren_s(prga_wren_s),
    .address_s(address_s), .data_s(data_s), .wren_s(wren_s),
    .prga_wren_d(prga_wren_d), .prga_data_d(prga_data_d)
  );

  typedef struct {
    bit            found;
    logic [KW-1:0] key;
    int            runs;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] plan_b [NRUN][64];
  int         plan_n [NRUN];
  bit         plan_co[NRUN];
  logic [7:0] bad_tbl[11] = '{8'h00, 8'h1F, 8'h21, 8'h40, 8'h41,
                              8'h5A, 8'h60, 8'h7B, 8'h7E, 8'h80, 8'hFF};

  int total = 0, nbad = 0;
  int cyc = 0, start_cyc = -100;
  int runs_seen = 0, done_cnt = 0, prun = 0;
  bit rst_seen = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a run is good iff exactly ML bytes, all a-z or space.
  function automatic bit ref_bad(int r);
    if (plan_n[r] != ML) return 1;
    for (int i = 0; i < plan_n[r]; i++) begin
      int b = int'(plan_b[r][i]);
      if (!((b >= 97 && b <= 122) || b == 32)) return 1;
    end
    return 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.found = 0;
    e.key   = KM;
    e.runs  = int'(KM - KS) + 1;
    for (int r = 0; r <= int'(KM - KS); r++) begin
      if (!ref_bad(r)) begin
        e.found = 1;
        e.key   = KS + KW'(r);
        e.runs  = r + 1;
        return e;
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] good_byte();
    int v = int'($urandom_range(0, 27));
    if (v == 26) return 8'h20;
    if (v == 27) return 8'h7A;
    return 8'(97 + v);
  endfunction

  function automatic logic [7:0] bad_byte();
    return bad_tbl[$urandom_range(0, 10)];
  endfunction

  task automatic fill(int r, int n, logic [7:0] b, bit co);
    plan_n[r]  = n;
    plan_co[r] = co;
    for (int i = 0; i < 64; i++) plan_b[r][i] = b;
  endtask

  task automatic rand_run(int r);
    int kind = int'($urandom_range(0, 5));
    plan_co[r] = 1'($urandom_range(0, 1));
    plan_n[r]  = (kind == 2) ? 31 : (kind == 3) ? 33 : 32;
    for (int i = 0; i < 64; i++)
      plan_b[r][i] = (kind == 4) ? bad_byte() : good_byte();
    if (kind == 1) plan_b[r][$urandom_range(0, 31)] = bad_byte();
  endtask

  // Phase models: S-RAM drives change every cycle; finishes after a
  // random delay; spurious finishes/D-writes when a phase is idle.
  initial begin
    int irem = 0, krem = 0, pi = 0, pr = 0;
    bit ib = 0, kb = 0, pb = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_seen) begin ib = 0; kb = 0; pb = 0; rst_seen = 0; end
      init_finish = 0; ksa_finish = 0; prga_finish = 0;
      prga_wren_d = 0; prga_data_d = 8'h00;
      {init_address_s, init_data_s} = 16'($urandom);
      {ksa_address_s, ksa_data_s}   = 16'($urandom);
      {prga_address_s, prga_data_s} = 16'($urandom);
      init_wren_s = ($urandom_range(0, 3) != 0);
      ksa_wren_s  = ($urandom_range(0, 3) != 0);
      prga_wren_s = ($urandom_range(0, 3) != 0);
      if (init_start) begin ib = 1; irem = int'($urandom_range(0, 9)); end
      if (ib) begin
        if (irem == 0) begin init_finish = 1; ib = 0; end
        else irem--;
      end else if ($urandom_range(0, 7) == 0) init_finish = 1;
      if (ksa_start) begin kb = 1; krem = int'($urandom_range(0, 9)); end
      if (kb) begin
        if (krem == 0) begin ksa_finish = 1; kb = 0; end
        else krem--;
      end else if ($urandom_range(0, 7) == 0) ksa_finish = 1;
      if (prga_start) begin
        pb = 1; pi = 0; pr = (prun < NRUN) ? prun : NRUN - 1; prun++;
      end
      if (pb) begin
        if (pi < plan_n[pr] && $urandom_range(0, 3) != 0) begin
          prga_wren_d = 1;
          prga_data_d = plan_b[pr][pi];
          pi++;
          if (pi == plan_n[pr] && plan_co[pr]) begin
            prga_finish = 1; pb = 0;
          end
        end else if (pi == plan_n[pr]) begin
          prga_finish = 1; pb = 0;
        end
      end else begin
        if ($urandom_range(0, 7) == 0) prga_finish = 1;
        if ($urandom_range(0, 7) == 0) prga_wren_d = 1;
      end
    end
  end

  // Monitor: S-RAM owner, start latencies, per-run key, and
  // scoreboard pop on every finish pulse.
  initial begin
    int ph = 0, lif = -100, lkf = -100, lpf = -100;
    logic [16:0] exp_mux;
    exp_t e;
    forever begin
      @(negedge clk);
      if (init_start) ph = 1;
      if (ksa_start)  ph = 2;
      if (prga_start) ph = 3;
      case (ph)
        1: exp_mux = {init_address_s, init_data_s, init_wren_s};
        2: exp_mux = {ksa_address_s, ksa_data_s, ksa_wren_s};
        3: exp_mux = {prga_address_s, prga_data_s, prga_wren_s};
        default: exp_mux = '0;
      endcase
      chk("sram_mux", {address_s, data_s, wren_s}, exp_mux);
      if (init_start) begin
        chk("init_start_lat",
            ((cyc - 1 == start_cyc) || (cyc - 3 == lpf)) ? 1 : 0, 1);
        chk("run_key", key, KS + KW'(runs_seen));
        runs_seen++;
      end
      if (ksa_start)  chk("ksa_start_lat", cyc - lif, 1);
      if (prga_start) chk("prga_start_lat", cyc - lkf, 1);
      if (ph == 1 && init_finish) begin lif = cyc; ph = 0; end
      if (ph == 2 && ksa_finish)  begin lkf = cyc; ph = 0; end
      if (ph == 3 && prga_finish) begin lpf = cyc; ph = 0; end
      if (finish) begin
        if (exp_q.size() == 0) begin
          total++; nbad++;
          $display("FAIL unexpected_finish: got 1 want 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("found", found, e.found);
          chk("final_key", key, e.key);
          chk("run_count", runs_seen, e.runs);
          chk("finish_lat", cyc - lpf, 2);
        end
        done_cnt++;
      end
      if (reset) begin ph = 0; rst_seen = 1; end
    end
  end

  task automatic do_search(bit extra_start);
    int   d0 = done_cnt;
    int   w;
    exp_t e = predict();
    @(posedge clk); #1;
    start = 1; start_cyc = cyc; runs_seen = 0; prun = 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 0;
    if (extra_start) begin
      repeat (2) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    for (w = 0; w < 3000; w++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    if (w == 3000) begin
      total++; nbad++;
      $display("FAIL search_timeout: got no finish want finish");
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("found_hold", found, e.found);
    chk("key_hold", key, e.key);
  endtask

  initial begin
    int w;
    for (int r = 0; r < NRUN; r++) fill(r, 32, 8'h61, 0);
    repeat (3) @(negedge clk);
    chk("rst_key", key, KS);
    chk("rst_found", found, 0);
    chk("rst_finish", finish, 0);
    chk("rst_starts", {init_start, ksa_start, prga_start}, 0);
    chk("rst_wren_s", wren_s, 0);
    @(posedge clk); #1;
    reset = 0;

    // plain sequencing: first key good
    for (int r = 0; r < NRUN; r++) fill(r, 32, 8'h61, 1);
    do_search(0);
    // one bad byte, then all 'z'
    fill(0, 32, 8'h61, 0); plan_b[0][5] = 8'h41;
    fill(1, 32, 8'h7A, 0);
    do_search(0);
    // exhaustion: every key bad, stops at KEY_MAX
    for (int r = 0; r < NRUN; r++) fill(r, 32, 8'h41, r[0]);
    do_search(0);
    // short message with last write on prga_finish
    fill(0, 31, 8'h20, 1);
    fill(1, 32, 8'h20, 1);
    do_search(0);
    // bad final byte coinciding with prga_finish
    fill(0, 32, 8'h61, 1); plan_b[0][31] = 8'h7B;
    fill(1, 32, 8'h61, 0); plan_b[1][0] = 8'h60;
    fill(2, 33, 8'h61, 1);
    fill(3, 32, 8'h7A, 1);
    do_search(1);

    for (int s = 0; s < 12; s++) begin
      for (int r = 0; r < NRUN; r++) rand_run(r);
      do_search(1'($urandom_range(0, 1)));
    end

    // reset during the second key's PRGA phase
    fill(0, 32, 8'h00, 0);
    fill(1, 32, 8'h61, 0);
    fill(2, 32, 8'h61, 0);
    fill(3, 32, 8'h61, 0);
    @(posedge clk); #1;
    start = 1; start_cyc = cyc; runs_seen = 0; prun = 0;
    @(posedge clk); #1;
    start = 0;
    for (w = 0; w < 3000; w++) begin
      @(negedge clk);
      if (prga_start && runs_seen == 2) break;
    end
    if (w == 3000) begin
      total++; nbad++;
      $display("FAIL reset_setup_timeout: got no prga_start want prga_start");
    end
    repeat (4) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrun_rst_key", key, KS);
    chk("midrun_rst_found", found, 0);
    chk("midrun_rst_wren_s", wren_s, 0);
    chk("midrun_rst_addr_s", address_s, 0);
    chk("midrun_rst_finish", finish, 0);
    repeat (20) @(negedge clk);
    chk("midrun_rst_idle", {init_start, ksa_start, prga_start, finish}, 0);

    fill(0, 32, 8'h61, 0);
    do_search(0);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
